// File: rtl/usb_ep_mux.sv
// N-channel AXI4-Stream packet mux feeding the USB packet encoder.
// Forwards one packet per start strobe and splits long transfers at MAX_PACKET beats.
module usb_ep_mux #(
  parameter int CHANNELS   = 4,
  parameter int WIDTH      = 8,
  parameter int MAX_PACKET = 512,
  parameter int SBITS      = $clog2(CHANNELS),
  parameter int LBITS      = $clog2(MAX_PACKET + 1)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start_i,
  input  logic [SBITS-1:0]          sel_i,
  input  logic                      abort_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      nak_o,
  output logic                      trunc_o,
  output logic [LBITS-1:0]          len_o,
  input  logic [CHANNELS-1:0]       ch_tvalid_i,
  output logic [CHANNELS-1:0]       ch_tready_o,
  input  logic [CHANNELS-1:0]       ch_tlast_i,
  input  logic [CHANNELS*WIDTH-1:0] ch_tdata_i,
  output logic                      m_tvalid_o,
  input  logic                      m_tready_i,
  output logic                      m_tlast_o,
  output logic [WIDTH-1:0]          m_tdata_o
);

  typedef enum logic {IDLE, XFER} state_e;

  state_e           state_q, state_d;
  logic [SBITS-1:0] sel_q, sel_d;
  logic [LBITS-1:0] cnt_q, cnt_d;
  logic [LBITS-1:0] len_q, len_d;
  logic             done_q, done_d;
  logic             nak_q, nak_d;
  logic             trunc_q, trunc_d;

  logic             start_ok;
  logic             cur_valid;
  logic             cur_last;
  logic [WIDTH-1:0] cur_data;
  logic             at_max;
  logic             xfer;
  logic             beat;
  logic             last_beat;

  // Channel lookups by comparison so an out-of-range sel_i simply matches nothing.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    start_ok  = 1'b0;
    cur_valid = 1'b0;
    cur_last  = 1'b0;
    cur_data  = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (sel_i == SBITS'(k)) start_ok = ch_tvalid_i[k];
      if (sel_q == SBITS'(k)) begin
        cur_valid = ch_tvalid_i[k];
        cur_last  = ch_tlast_i[k];
        cur_data  = ch_tdata_i[k*WIDTH +: WIDTH];
      end
    end
  end

  assign at_max    = (cnt_q == LBITS'(MAX_PACKET - 1));
  assign xfer      = (state_q == XFER) && !abort_i;
  assign beat      = xfer && cur_valid && m_tready_i;
  assign last_beat = beat && (cur_last || at_max);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      done_q  <= 1'b0;
      nak_q   <= 1'b0;
      trunc_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      done_q  <= done_d;
      nak_q   <= nak_d;
      trunc_q <= trunc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    trunc_d = trunc_q;
    done_d  = 1'b0;
    nak_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (start_ok) begin
            state_d = XFER;
            sel_d   = sel_i;
            cnt_d   = '0;
          end else begin
            nak_d = 1'b1;
          end
        end
      end
      XFER: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (last_beat) begin
          // cnt is left at its final value so it never passes MAX_PACKET-1.
          state_d = IDLE;
          done_d  = 1'b1;
          len_d   = cnt_q + 1'b1;
          trunc_d = !cur_last;
        end else if (beat) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_tvalid_o  = xfer && cur_valid;
    m_tlast_o   = xfer && (cur_last || at_max);
    m_tdata_o   = cur_data;
    ch_tready_o = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (xfer && (sel_q == SBITS'(k))) ch_tready_o[k] = m_tready_i;
    end
    busy_o  = (state_q == XFER);
    done_o  = done_q;
    nak_o   = nak_q;
    trunc_o = trunc_q;
    len_o   = len_q;
  end

endmodule

// File: doc/usb_ep_mux.md
# usb_ep_mux

Parametrised N-channel AXI4-Stream packet multiplexer between the USB endpoint sources (control pipe 0, vendor control, bulk IN endpoints) and the packet encoder's transaction data input. The transaction FSM issues a start strobe with a channel select for each IN/control-read data stage. The mux then forwards exactly one USB data packet from that channel, forcing `tlast` at the maximum packet size so long transfers split into max-sized packets. It replaces the fixed 2:1 control-stream mux and reports per-packet length, truncation and NAK status back to the transaction FSM.

## Interface
Parameters:
- `CHANNELS`, 4: number of source streams, ≥2.
- `WIDTH`, 8: data width, in bits.
- `MAX_PACKET`, 512: maximum beats per packet, ≥1 (64 for control-only builds).
- `SBITS`, `$clog2(CHANNELS)`: width of the select input.
- `LBITS`, `$clog2(MAX_PACKET+1)`: width of the length output.

Ports:
- `clock` in 1: single clock domain.
- `reset` in 1: asynchronous, active-low reset.
- `start_i` in 1: one-cycle strobe requesting one packet.
- `sel_i` in SBITS: channel index, sampled with `start_i`.
- `abort_i` in 1: cancels the packet in progress (host timeout or bus reset).
- `busy_o` out 1: high while a packet is being forwarded.
- `done_o` out 1: one-cycle pulse after the last beat.
- `nak_o` out 1: one-cycle pulse when a start cannot be serviced.
- `trunc_o` out 1: valid with `done_o`; high when `tlast` was forced at `MAX_PACKET`.
- `len_o` out LBITS: valid with `done_o`; number of beats sent.
- `ch_tvalid_i` in CHANNELS: per-channel valid.
- `ch_tready_o` out CHANNELS: per-channel ready.
- `ch_tlast_i` in CHANNELS: per-channel last.
- `ch_tdata_i` in CHANNELS*WIDTH: channel k occupies bits `[k*WIDTH +: WIDTH]`.
- `m_tvalid_o` out 1: valid to the encoder.
- `m_tready_i` in 1: ready from the encoder.
- `m_tlast_o` out 1: last to the encoder.
- `m_tdata_o` out WIDTH: data to the encoder.

## Operation
- The FSM has two states, IDLE and XFER. Registered `sel_q` holds the selected channel and `cnt` (LBITS) counts beats.
- IDLE, `start_i`=1 with `sel_i` < CHANNELS and `ch_tvalid_i[sel_i]`=1:
  - load `sel_q`, clear `cnt`, go to XFER.
- IDLE, `start_i`=1 with `sel_i` ≥ CHANNELS or `ch_tvalid_i[sel_i]`=0:
  - pulse `nak_o` on the next cycle and stay in IDLE.
- XFER output path is combinational:
  - `m_tvalid_o` = `ch_tvalid_i[sel_q]`.
  - `m_tdata_o` = channel `sel_q` data.
  - `m_tlast_o` = `ch_tlast_i[sel_q]` OR (`cnt` == MAX_PACKET−1).
  - `ch_tready_o[sel_q]` = `m_tready_i`; all other ready bits are 0.
- Beat: `m_tvalid_o` & `m_tready_i`. Each beat increments `cnt`.
- Last beat (a beat with `m_tlast_o`=1): go to IDLE on the next cycle and, on that cycle:
  - `done_o`=1.
  - `len_o` = `cnt`+1.
  - `trunc_o` = NOT `ch_tlast_i[sel_q]` as sampled on the last beat.
- Truncation: the source's remaining beats are not consumed and stay queued for the next start on the same channel.
- `abort_i`=1 in XFER:
  - forces `m_tvalid_o`=0 and all `ch_tready_o`=0 in the same cycle, so no beat occurs.
  - next state is IDLE with no `done_o`.
  - `abort_i` overrides a coincident last beat.
- `start_i` in XFER is ignored; no `nak_o`.
- In IDLE, `m_tvalid_o`, `m_tlast_o` and all `ch_tready_o` are 0. `m_tdata_o` is don't-care; drive channel `sel_q`.

## Timing
- Reset (`reset`=0, asynchronous) forces the following; the same values apply on release:
  - state IDLE, `sel_q`=0, `cnt`=0.
  - `busy_o`=0, `done_o`=0, `nak_o`=0, `trunc_o`=0, `len_o`=0.
  - `m_tvalid_o`=0, all `ch_tready_o`=0.
- Start latency: with `start_i` at cycle N, the first beat can occur at cycle N+1. `busy_o` is registered and equals (state==XFER).
- Throughput: one beat per cycle. Zero-cycle pass-through, no buffering; AXI4-Stream rules hold (valid never depends on ready).
- `done_o`, `nak_o`, `trunc_o` and `len_o` are registered. `len_o` and `trunc_o` hold until the next `done_o`.
- A new `start_i` is accepted on the same cycle `done_o` is high, since state is already IDLE. Minimum packet-to-packet spacing is 2 cycles.
- Single-beat packet (source `tlast` on the first beat, or MAX_PACKET=1): `len_o`=1.
- `cnt` never exceeds MAX_PACKET−1; no wrap is possible.

## Test plan
Bench configuration: CHANNELS=3, WIDTH=8, MAX_PACKET=8.
- Ch1 holds 5 bytes 0xA0..0xA4 (`tlast` on 0xA4), start with sel=1, `m_tready_i`=1 → 5 beats on consecutive cycles; `done_o` with `len_o`=5, `trunc_o`=0; `ch_tready_o[0]` and `[2]` stay 0 throughout.
- Ch2 holds 20 bytes, three starts with sel=2 → packets of 8, 8, 4 beats; `trunc_o`=1, 1, 0; data continuous across packets.
- Start with sel=0 and ch0 idle, then sel=3 → `nak_o` pulses on both, `busy_o` stays 0, no beats.
- Ch1 packet of 6 with `m_tready_i` toggling 1010… → exactly 6 beats, `len_o`=6; data unchanged during stalls.
- `abort_i` asserted after 3 beats of an 8-byte packet → no further beats, no `done_o`. A new start on the same channel delivers the remaining 5 bytes with `len_o`=5.
- Assert `reset` low mid-packet → all outputs 0 immediately; after release, a start yields a normal packet.
